// File: rtl/sel_f2a_pkg.sv
// Shared constants for the FTDI receive selector: destination codes,
// header field positions and one-hot FSM state encoding.
package sel_f2a_pkg;

    localparam logic [1:0] DEST_CPU = 2'b00;
    localparam logic [1:0] DEST_IQ  = 2'b01;

    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 30;
    localparam int LEN_MSB  = 10;
    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    localparam int ST_IDLE    = 0;
    localparam int ST_CPU     = 1;
    localparam int ST_FIFO    = 2;
    localparam int ST_DISCARD = 3;
    localparam int ST_W       = 4;

    localparam logic [ST_W-1:0] S_IDLE    = 4'b0001;
    localparam logic [ST_W-1:0] S_CPU     = 4'b0010;
    localparam logic [ST_W-1:0] S_FIFO    = 4'b0100;
    localparam logic [ST_W-1:0] S_DISCARD = 4'b1000;

    function automatic logic dest_is_reserved(input logic [1:0] dest);
        return (dest != DEST_CPU) && (dest != DEST_IQ);
    endfunction

endpackage

// File: rtl/f2a_hdr_decode.sv
// Combinational packet-header decoder: splits a header word into
// destination, length field and a reserved-destination flag.
module f2a_hdr_decode
    import sel_f2a_pkg::*;
#(
    parameter int FT_DATA_WIDTH = 32
) (
    input  logic [FT_DATA_WIDTH-1:0] hdr_i,
    output logic [1:0]               dest_o,
    output logic [LEN_W-1:0]         len_o,
    output logic                     reserved_o
);

    assign dest_o     = hdr_i[DEST_MSB:DEST_LSB];
    assign len_o      = hdr_i[LEN_MSB:LEN_LSB];
    assign reserved_o = dest_is_reserved(dest_o);

    // Middle header bits carry no meaning.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^hdr_i[DEST_LSB-1:LEN_MSB+1];

endmodule

// File: rtl/sel_f2a.sv
// FTDI receive selector: routes host packets to the ECPU FIFO or the TX IQ FIFO.
// Optional macro SEL_F2A_DROP_CNT_EN adds a saturating discarded-word counter.
module sel_f2a
    import sel_f2a_pkg::*;
#(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic                     we_i,
    input  logic [FT_DATA_WIDTH-1:0] data_i,
    output logic                     ready_o,
    output logic [FT_DATA_WIDTH-1:0] cpu_data_o,
    output logic                     cpu_we_o,
    input  logic                     cpu_afull_i,
    output logic [IQ_PAIR_WIDTH-1:0] fifo_data_o,
    output logic                     fifo_we_o,
    input  logic                     fifo_afull_i,
    output logic [7:0]               fifoin_wc_o,
    output logic                     hdr_err_o
`ifdef SEL_F2A_DROP_CNT_EN
    ,
    output logic [15:0]              drop_cnt_o
`endif
);

    localparam int HALF_W = IQ_PAIR_WIDTH / 2;

    logic [ST_W-1:0]          state_q, state_d;
    logic [LEN_W-1:0]         packet_cnt_q, packet_cnt_d;
    logic [FT_DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic                     cpu_we_q, cpu_we_d;
    logic [IQ_PAIR_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                     fifo_we_q, fifo_we_d;
    logic [7:0]               fifoin_wc_q, fifoin_wc_d;
    logic                     hdr_err_q, hdr_err_d;
`ifdef SEL_F2A_DROP_CNT_EN
    logic [15:0]              drop_cnt_q, drop_cnt_d;
`endif

    logic [1:0]       hdr_dest;
    logic [LEN_W-1:0] hdr_len;
    logic             hdr_reserved;
    logic             accept;
    logic             last_word;

    f2a_hdr_decode #(
        .FT_DATA_WIDTH (FT_DATA_WIDTH)
    ) u_hdr_decode (
        .hdr_i      (data_i),
        .dest_o     (hdr_dest),
        .len_o      (hdr_len),
        .reserved_o (hdr_reserved)
    );

    // The afull inputs already reserve room for the one registered write in flight.
    always_comb begin
        case (state_q)
            S_CPU:   ready_o = ~cpu_afull_i;
            S_FIFO:  ready_o = ~fifo_afull_i;
            default: ready_o = 1'b1;
        endcase
    end

    assign accept    = we_i && ready_o;
    assign last_word = (packet_cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        packet_cnt_d = packet_cnt_q;
        cpu_data_d   = cpu_data_q;
        cpu_we_d     = 1'b0;
        fifo_data_d  = fifo_data_q;
        fifo_we_d    = 1'b0;
        fifoin_wc_d  = fifoin_wc_q;
        hdr_err_d    = 1'b0;
`ifdef SEL_F2A_DROP_CNT_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    packet_cnt_d = hdr_len;
                    if (hdr_reserved) begin
                        state_d   = S_DISCARD;
                        hdr_err_d = 1'b1;
                    end else if (hdr_dest == DEST_CPU) begin
                        state_d = S_CPU;
                    end else begin
                        state_d = S_FIFO;
                    end
                end
            end
            S_CPU: begin
                if (accept) begin
                    cpu_data_d   = data_i;
                    cpu_we_d     = 1'b1;
                    packet_cnt_d = packet_cnt_q - 1'b1;
                    // Count lands together with the last word's strobe.
                    if (last_word) begin
                        fifoin_wc_d = fifoin_wc_q + 8'd1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_FIFO: begin
                if (accept) begin
                    fifo_data_d  = {data_i[QSTART_BIT_INDEX +: HALF_W], data_i[0 +: HALF_W]};
                    fifo_we_d    = 1'b1;
                    packet_cnt_d = packet_cnt_q - 1'b1;
                    if (last_word) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (accept) begin
                    packet_cnt_d = packet_cnt_q - 1'b1;
`ifdef SEL_F2A_DROP_CNT_EN
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
`endif
                    if (last_word) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            packet_cnt_q <= '0;
            cpu_data_q   <= '0;
            cpu_we_q     <= 1'b0;
            fifo_data_q  <= '0;
            fifo_we_q    <= 1'b0;
            fifoin_wc_q  <= '0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            packet_cnt_q <= packet_cnt_d;
            cpu_data_q   <= cpu_data_d;
            cpu_we_q     <= cpu_we_d;
            fifo_data_q  <= fifo_data_d;
            fifo_we_q    <= fifo_we_d;
            fifoin_wc_q  <= fifoin_wc_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

`ifdef SEL_F2A_DROP_CNT_EN
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign cpu_data_o  = cpu_data_q;
    assign cpu_we_o    = cpu_we_q;
    assign fifo_data_o = fifo_data_q;
    assign fifo_we_o   = fifo_we_q;
    assign fifoin_wc_o = fifoin_wc_q;
    assign hdr_err_o   = hdr_err_q;

endmodule

// File: tb/tb_sel_f2a.sv
// Self-checking bench for sel_f2a: spec-level packet model feeds scoreboard
// queues, a negedge monitor pops and compares every write strobe.
module tb_sel_f2a;

    logic        clk_i = 1'b0;
    logic        reset_n = 1'b1;
    logic        we_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        ready_o;
    logic [31:0] cpu_data_o;
    logic        cpu_we_o;
    logic        cpu_afull_i = 1'b0;
    logic [23:0] fifo_data_o;
    logic        fifo_we_o;
    logic        fifo_afull_i = 1'b0;
    logic [7:0]  fifoin_wc_o;
    logic        hdr_err_o;
`ifdef SEL_F2A_DROP_CNT_EN
    logic [15:0] drop_cnt_o;
`endif

    sel_f2a dut (
        .clk_i        (clk_i),
        .reset_n      (reset_n),
        .we_i         (we_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .cpu_data_o   (cpu_data_o),
        .cpu_we_o     (cpu_we_o),
        .cpu_afull_i  (cpu_afull_i),
        .fifo_data_o  (fifo_data_o),
        .fifo_we_o    (fifo_we_o),
        .fifo_afull_i (fifo_afull_i),
        .fifoin_wc_o  (fifoin_wc_o),
        .hdr_err_o    (hdr_err_o)
`ifdef SEL_F2A_DROP_CNT_EN
        ,
        .drop_cnt_o   (drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  wc;
    } cpu_exp_t;

    typedef enum int {M_IDLE, M_CPU, M_FIFO, M_DISC} mstate_t;

    cpu_exp_t    cpu_q[$];
    logic [23:0] fifo_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_cpu_seen = 0;
    int n_fifo_seen = 0;
    int n_err_seen = 0;

    mstate_t m_state = M_IDLE;
    int      m_cnt = 0;
    int      m_wc = 0;
    int      m_errs = 0;
    int      m_drops = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready(input logic caf, input logic faf);
        case (m_state)
            M_CPU:   return ~caf;
            M_FIFO:  return ~faf;
            default: return 1'b1;
        endcase
    endfunction

    // Spec-level packet model: decides what each accepted word must produce.
    task automatic model_accept(input logic [31:0] d);
        logic [31:0] w;
        logic [23:0] iq;
        w = d;
        case (m_state)
            M_IDLE: begin
                m_cnt = int'(w[10:0]);
                case (w[31:30])
                    2'b00:   m_state = M_CPU;
                    2'b01:   m_state = M_FIFO;
                    default: begin
                        m_state = M_DISC;
                        m_errs++;
                    end
                endcase
            end
            M_CPU: begin
                if (m_cnt == 0) m_wc = (m_wc + 1) % 256;
                cpu_q.push_back('{data: w, wc: 8'(m_wc)});
                if (m_cnt == 0) m_state = M_IDLE;
                m_cnt--;
            end
            M_FIFO: begin
                iq = {w[27:16], w[11:0]};
                fifo_q.push_back(iq);
                if (m_cnt == 0) m_state = M_IDLE;
                m_cnt--;
            end
            default: begin
                m_drops++;
                if (m_cnt == 0) m_state = M_IDLE;
                m_cnt--;
            end
        endcase
    endtask

    // Called at posedge+1; inputs apply to the next rising edge.
    task automatic drive(input logic we, input logic [31:0] d, input logic caf, input logic faf);
        logic er;
        we_i = we;
        data_i = d;
        cpu_afull_i = caf;
        fifo_afull_i = faf;
        #1;
        er = exp_ready(caf, faf);
        check("ready_o", 32'(ready_o), 32'(er));
        if (we && er) model_accept(d);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_we"}, 32'(cpu_we_o), 32'h0);
        check({tag, "_fifo_we"}, 32'(fifo_we_o), 32'h0);
        check({tag, "_hdr_err"}, 32'(hdr_err_o), 32'h0);
        check({tag, "_cpu_data"}, cpu_data_o, 32'h0);
        check({tag, "_fifo_data"}, 32'(fifo_data_o), 32'h0);
        check({tag, "_wc"}, 32'(fifoin_wc_o), 32'h0);
        check({tag, "_ready"}, 32'(ready_o), 32'h1);
`ifdef SEL_F2A_DROP_CNT_EN
        check({tag, "_drop_cnt"}, 32'(drop_cnt_o), 32'h0);
`endif
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_cnt = 0;
        m_wc = 0;
        m_drops = 0;
        cpu_q.delete();
        fifo_q.delete();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_cpu_q_left"}, 32'(cpu_q.size()), 32'h0);
        check({tag, "_fifo_q_left"}, 32'(fifo_q.size()), 32'h0);
    endtask

    always @(negedge clk_i) begin
        cpu_exp_t    ce;
        logic [23:0] fe;
        if (cpu_we_o === 1'b1 && fifo_we_o === 1'b1) check("strobe_excl", 32'h1, 32'h0);
        if (cpu_we_o === 1'b1) begin
            n_cpu_seen++;
            if (cpu_q.size() == 0) begin
                check("cpu_unexpected", 32'(cpu_we_o), 32'h0);
            end else begin
                ce = cpu_q.pop_front();
                check("cpu_data", cpu_data_o, ce.data);
                check("cpu_wc", 32'(fifoin_wc_o), 32'(ce.wc));
            end
        end
        if (fifo_we_o === 1'b1) begin
            n_fifo_seen++;
            if (fifo_q.size() == 0) begin
                check("fifo_unexpected", 32'(fifo_we_o), 32'h0);
            end else begin
                fe = fifo_q.pop_front();
                check("fifo_data", 32'(fifo_data_o), 32'(fe));
            end
        end
        if (hdr_err_o === 1'b1) n_err_seen++;
    end

    initial begin
        int c0;
        int f0;
        #1 reset_n = 1'b0;
        #2 check_reset_vals("rst0");
        repeat (2) @(posedge clk_i);
        #1 reset_n = 1'b1;

        // CPU packet of three words
        c0 = n_cpu_seen; f0 = n_fifo_seen;
        drive(1'b1, 32'h0000_0002, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00A1, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00A2, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00A3, 1'b0, 1'b0);
        idle(3);
        check("cpu_pkt_strobes", 32'(n_cpu_seen - c0), 32'd3);
        check("cpu_pkt_fifo_strobes", 32'(n_fifo_seen - f0), 32'd0);
        check("cpu_pkt_wc", 32'(fifoin_wc_o), 32'd1);
        check_drained("cpu_pkt");

        // IQ packet of one word
        c0 = n_cpu_seen; f0 = n_fifo_seen;
        drive(1'b1, 32'h4000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h0ABC_0123, 1'b0, 1'b0);
        idle(2);
        check("iq_pkt_strobes", 32'(n_fifo_seen - f0), 32'd1);
        check("iq_pkt_cpu_strobes", 32'(n_cpu_seen - c0), 32'd0);
        check("iq_pkt_wc", 32'(fifoin_wc_o), 32'd1);
        check_drained("iq_pkt");

        // Backpressure: cpu_afull_i high for three cycles mid-packet
        c0 = n_cpu_seen;
        drive(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00B1, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00B2, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_00B2, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_00B2, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_00B2, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00B3, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00B4, 1'b0, 1'b0);
        idle(2);
        check("bp_strobes", 32'(n_cpu_seen - c0), 32'd4);
        check("bp_wc", 32'(fifoin_wc_o), 32'd2);
        check_drained("bp");

        // Reserved header, two discarded words, then a one-word CPU packet
        c0 = n_cpu_seen; f0 = n_fifo_seen;
        drive(1'b1, 32'hC000_0001, 1'b0, 1'b0);
        drive(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        drive(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00D1, 1'b0, 1'b0);
        idle(2);
        check("rsv_hdr_err_pulses", 32'(n_err_seen), 32'(m_errs));
        check("rsv_cpu_strobes", 32'(n_cpu_seen - c0), 32'd1);
        check("rsv_fifo_strobes", 32'(n_fifo_seen - f0), 32'd0);
        check("rsv_wc", 32'(fifoin_wc_o), 32'd3);
`ifdef SEL_F2A_DROP_CNT_EN
        check("rsv_drop_cnt", 32'(drop_cnt_o), 32'd2);
`endif
        check_drained("rsv");

        // Reset after two of five IQ words; next word is a CPU header
        f0 = n_fifo_seen;
        drive(1'b1, 32'h4000_0004, 1'b0, 1'b0);
        drive(1'b1, 32'h0001_0002, 1'b0, 1'b0);
        drive(1'b1, 32'h0003_0004, 1'b0, 1'b0);
        idle(1);
        check("midrst_delivered", 32'(n_fifo_seen - f0), 32'd2);
        reset_n = 1'b0;
        #1 check_reset_vals("midrst");
        model_reset();
        @(posedge clk_i);
        #1 reset_n = 1'b1;
        c0 = n_cpu_seen; f0 = n_fifo_seen;
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_00E1, 1'b0, 1'b0);
        idle(2);
        check("midrst_cpu_strobes", 32'(n_cpu_seen - c0), 32'd1);
        check("midrst_fifo_strobes", 32'(n_fifo_seen - f0), 32'd0);
        check("midrst_wc", 32'(fifoin_wc_o), 32'd1);

        // Counter wrap: 256 one-word CPU packets from a fresh reset
        reset_n = 1'b0;
        #1 check_reset_vals("wraprst");
        model_reset();
        @(posedge clk_i);
        #1 reset_n = 1'b1;
        c0 = n_cpu_seen;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
            drive(1'b1, $urandom, 1'b0, 1'b0);
            if (i == 254) check("wrap_wc_255", 32'(fifoin_wc_o), 32'd255);
        end
        idle(2);
        check("wrap_strobes", 32'(n_cpu_seen - c0), 32'd256);
        check("wrap_wc", 32'(fifoin_wc_o), 32'd0);
        check_drained("wrap");

        // Maximum-length packet, then an IQ packet proves return to idle
        c0 = n_cpu_seen; f0 = n_fifo_seen;
        drive(1'b1, 32'h0000_07FF, 1'b0, 1'b0);
        for (int i = 0; i < 2048; i++) drive(1'b1, 32'(i) ^ 32'h5A5A_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h4000_0000, 1'b0, 1'b0);
        drive(1'b1, 32'h0FED_0CBA, 1'b0, 1'b0);
        idle(2);
        check("long_strobes", 32'(n_cpu_seen - c0), 32'd2048);
        check("long_then_iq", 32'(n_fifo_seen - f0), 32'd1);
        check("long_wc", 32'(fifoin_wc_o), 32'd1);
        check_drained("long");
        check("final_hdr_err_pulses", 32'(n_err_seen), 32'(m_errs));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sel_f2a.md
Name: sel_f2a

Overview:
- Receive-side counterpart of the FTDI transmit selector.
- Accepts 32-bit words written by the FTDI front end (host -> device), parses a one-word packet header, and routes the payload to one of two places:
  - the ECPU input FIFO, as 32-bit words;
  - the TX IQ sample FIFO, as 24-bit packed IQ pairs.
- Reports completed CPU packets to the ECPU through a wrapping word counter.

Parameters:
- FT_DATA_WIDTH, 32, FTDI bus width.
- IQ_PAIR_WIDTH, 24, packed IQ pair width. I occupies the low half; Q occupies the high half.
- QSTART_BIT_INDEX, 16, bit position of Q sample LSB within an FTDI word.

Ports:
- clk_i  in  1  FTDI-side clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- we_i  in  1  FTDI word valid.
- data_i  in  FT_DATA_WIDTH  FTDI word.
- ready_o  out  1  block can accept data_i this cycle (combinational).
- cpu_data_o  out  FT_DATA_WIDTH  word to ECPU FIFO.
- cpu_we_o  out  1  ECPU FIFO write strobe.
- cpu_afull_i  in  1  ECPU FIFO has at most 1 free slot.
- fifo_data_o  out  IQ_PAIR_WIDTH  IQ pair to TX FIFO.
- fifo_we_o  out  1  TX FIFO write strobe.
- fifo_afull_i  in  1  TX FIFO has at most 1 free slot.
- fifoin_wc_o  out  8  count of completed CPU packets, wraps mod 256.
- hdr_err_o  out  1  one-cycle pulse on reserved destination header.

Behaviour:
- Transfer rule: a word is accepted when we_i && ready_o.
- Header word format:
  - bits[31:30] = destination: 00 CPU, 01 IQ FIFO, 10/11 reserved.
  - bits[10:0] = payload length - 1 (1..2048 words).
  - All other bits are ignored.
- State machine (one-hot, 4 states):
  - ST_IDLE:
    - ready_o = 1.
    - Accepted word is the header. Load packet_cnt <= len field.
    - dest 00 -> ST_CPU; dest 01 -> ST_FIFO; reserved -> ST_DISCARD with hdr_err_o = 1 next cycle.
    - The header word itself is never forwarded.
  - ST_CPU:
    - ready_o = ~cpu_afull_i.
    - Each accepted word is registered to cpu_data_o, with cpu_we_o = 1 on the following cycle (latency 1).
  - ST_FIFO:
    - ready_o = ~fifo_afull_i.
    - fifo_data_o <= {data_i[QSTART_BIT_INDEX+IQ_PAIR_WIDTH/2-1:QSTART_BIT_INDEX], data_i[IQ_PAIR_WIDTH/2-1:0]}.
    - fifo_we_o = 1 on the following cycle.
  - ST_DISCARD:
    - ready_o = 1.
    - Accepted words are consumed and not forwarded.
  - In all three payload states: on each accepted word, decrement packet_cnt (11-bit). When a word is accepted with packet_cnt == 0, return to ST_IDLE.
- Write strobes: cpu_we_o and fifo_we_o are 0 in any cycle following a non-accepted cycle; no bubbles are filled.
- Strobe exclusivity: cpu_we_o and fifo_we_o are never high together.
- fifoin_wc_o timing:
  - Increments by 1 in the same cycle that cpu_we_o carries the last word of a CPU packet.
  - The ECPU observes the count and the last word together.
  - Wraps 255 -> 0.
- Backpressure:
  - The afull inputs account for the single in-flight registered write.
  - A full-to-accept transition takes effect combinationally the same cycle.
  - Idle cycles with we_i = 0 cause no state change.
- Length 0 field: exactly one payload word.
- Back-to-back packets: a header may be accepted the cycle after the last payload word, with no dead cycle.
- Reset values:
  - ready_o follows ST_IDLE (= 1).
  - cpu_we_o, fifo_we_o, hdr_err_o = 0.
  - cpu_data_o, fifo_data_o, fifoin_wc_o, packet_cnt = 0.
- Reset mid-packet: the packet is abandoned and the FSM returns to ST_IDLE. The next accepted word is treated as a header. Partially delivered words are not retracted.
- Unreachable state codes: go to ST_IDLE.

Optional Feature:
- Macro: SEL_F2A_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt_o [15:0].
  - Counts every payload word accepted in ST_DISCARD, saturating at 16'hFFFF.
  - Reset to 0.
  - Never cleared otherwise.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package sel_f2a_pkg contains:
  - destination codes: DEST_CPU = 2'b00, DEST_IQ = 2'b01;
  - header field bit positions (DEST_MSB/LSB, LEN_MSB/LSB);
  - state indices: ST_IDLE = 0, ST_CPU = 1, ST_FIFO = 2, ST_DISCARD = 3.
- Sub-module f2a_hdr_decode (combinational):
  - Input: header word.
  - Outputs: destination, length, reserved flag.
  - Reusable by the ECPU firmware model.

Test Plan:
- CPU packet: header 32'h0000_0002 then 3 words A1, A2, A3 with we_i continuous, afull low -> cpu_we_o high 3 cycles starting 2 cycles after the header, carrying A1..A3; fifoin_wc_o 0 -> 1 with A3; fifo_we_o stays 0.
- IQ packet: header 32'h4000_0000, word 32'h0ABC_0123 -> one fifo_we_o with fifo_data_o = 24'hABC123; fifoin_wc_o unchanged.
- Backpressure:
  - Stimulus: CPU packet of 4 words; cpu_afull_i high for 3 cycles mid-packet.
  - Required response: ready_o low exactly those cycles; no word lost or duplicated; 4 total strobes.
- Reserved header:
  - Stimulus: 32'hC000_0001, then 2 words, then CPU header 32'h0000_0000 and 1 word.
  - Required response:
    - hdr_err_o pulse once.
    - Discarded words not forwarded.
    - Following CPU word delivered.
    - drop_cnt_o = 2 with SEL_F2A_DROP_CNT_EN.
- Wrap and boundary: 256 CPU packets of length 1 -> fifoin_wc_o returns to 0. One 2048-word packet (len field 11'h7FF) -> exactly 2048 strobes, then FSM back in ST_IDLE.
- Reset mid-packet: reset_n low after 2 of 5 IQ payload words -> all outputs at reset values; the next word 32'h0000_0000 is treated as a CPU header.
